// File: rtl/hack_cpu_mc_pkg.sv
`default_nettype none
// ============================================================================
// hack_pkg : shared word/state types, ISA field positions and jump codes
//            for the multi-cycle Hack CPU.
// Revision : 1.0
// ============================================================================
package hack_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    MREAD  = 3'd2,
    EXEC   = 3'd3,
    MWRITE = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Instruction field bit positions
  localparam int c_bit_ci = 15;
  localparam int c_bit_a  = 12;
  localparam int c_bit_zx = 11;
  localparam int c_bit_nx = 10;
  localparam int c_bit_zy = 9;
  localparam int c_bit_ny = 8;
  localparam int c_bit_f  = 7;
  localparam int c_bit_no = 6;
  localparam int c_bit_d1 = 5;
  localparam int c_bit_d2 = 4;
  localparam int c_bit_d3 = 3;
  localparam int c_j_hi   = 2;
  localparam int c_j_lo   = 0;

  // Single-condition jump codes; composite codes are their bitwise OR
  localparam logic [2:0] c_jgt = 3'b001;
  localparam logic [2:0] c_jeq = 3'b010;
  localparam logic [2:0] c_jlt = 3'b100;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (((j & c_jlt) != 3'b000) && ng) ||
           (((j & c_jeq) != 3'b000) && zr) ||
           (((j & c_jgt) != 3'b000) && !zr && !ng);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hack_cpu_mc_alu.sv
`default_nettype none
// ============================================================================
// hack_alu : combinational Hack ALU (zx,nx,zy,ny,f,no -> out,zr,ng).
// Revision : 1.0
// ============================================================================
module hack_alu
  import hack_pkg::*;
(
  input  word_t x,
  input  word_t y,
  input  logic  zx,
  input  logic  nx,
  input  logic  zy,
  input  logic  ny,
  input  logic  f,
  input  logic  no,
  output word_t out,
  output logic  zr,
  output logic  ng
);

  word_t w_x0;
  word_t w_x1;
  word_t w_y0;
  word_t w_y1;
  word_t w_f;

  assign w_x0 = zx ? 16'h0000 : x;
  assign w_x1 = nx ? ~w_x0 : w_x0;
  assign w_y0 = zy ? 16'h0000 : y;
  assign w_y1 = ny ? ~w_y0 : w_y0;
  assign w_f  = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign out  = no ? ~w_f : w_f;
  assign zr   = (out == 16'h0000);
  assign ng   = out[15];

endmodule
`default_nettype wire

// File: rtl/hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// hack_cpu_mc : multi-cycle Hack CPU with handshaked instruction/data ports,
//               single-step control and jump-to-self halt detection.
// Revision    : 1.0
// ============================================================================
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int HALT_DETECT = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_rd_req,
  output logic              dmem_wr_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  input  logic              step_en,
  input  logic              step,
  output logic              halted,
  output logic [ADDR_W-1:0] debug_pc,
  output logic [15:0]       debug_inst,
  output logic [15:0]       debug_inM,
  output logic              debug_retired
);

  localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

  state_t            r_state;
  logic              r_started;
  logic [ADDR_W-1:0] r_pc;
  word_t             r_a;
  word_t             r_d;
  word_t             r_ir;
  word_t             r_inm;

  state_t            w_state;
  state_t            w_state_nxt;
  state_t            w_after_retire;
  word_t             w_y;
  word_t             w_alu_out;
  logic              w_zr;
  logic              w_ng;
  logic              w_is_c;
  logic              w_mem_wr;
  logic              w_jump;
  logic              w_halt_hit;
  logic              w_retire;
  logic [ADDR_W-1:0] w_a_addr;
  logic [2:0]        w_j;

  // Until the first clock after reset the state follows step_en directly,
  // so the reset value of the FSM tracks that input without an async load.
  assign w_state = r_started ? r_state : (step_en ? IDLE : FETCH);

  assign w_is_c     = r_ir[c_bit_ci];
  assign w_mem_wr   = w_is_c && r_ir[c_bit_d3];
  assign w_j        = r_ir[c_j_hi:c_j_lo];
  assign w_a_addr   = r_a[ADDR_W-1:0];
  assign w_y        = r_ir[c_bit_a] ? r_inm : r_a;
  assign w_jump     = w_is_c && jump_taken(w_j, w_zr, w_ng);
  assign w_halt_hit = (HALT_DETECT != 0) && w_jump && (w_a_addr == r_pc);
  assign w_retire   = ((w_state == EXEC) && !w_mem_wr) ||
                      ((w_state == MWRITE) && dmem_ack);

  assign w_after_retire = w_halt_hit ? HALT : (step_en ? IDLE : FETCH);

  hack_alu u_alu (
    .x   (r_d),
    .y   (w_y),
    .zx  (r_ir[c_bit_zx]),
    .nx  (r_ir[c_bit_nx]),
    .zy  (r_ir[c_bit_zy]),
    .ny  (r_ir[c_bit_ny]),
    .f   (r_ir[c_bit_f]),
    .no  (r_ir[c_bit_no]),
    .out (w_alu_out),
    .zr  (w_zr),
    .ng  (w_ng)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      IDLE:    if (step || !step_en) w_state_nxt = FETCH;
      FETCH:   if (imem_ack)
                 w_state_nxt = (imem_rdata[c_bit_ci] && imem_rdata[c_bit_a]) ? MREAD : EXEC;
      MREAD:   if (dmem_ack) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = w_mem_wr ? MWRITE : w_after_retire;
      MWRITE:  if (dmem_ack) w_state_nxt = w_after_retire;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // Requests are gated by reset so an interrupted handshake drops immediately
  always_comb begin
    imem_req    = 1'b0;
    dmem_rd_req = 1'b0;
    dmem_wr_req = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = 16'h0000;
    halted      = 1'b0;
    if (reset) begin
      case (w_state)
        FETCH:  imem_req = 1'b1;
        MREAD: begin
          dmem_rd_req = 1'b1;
          dmem_addr   = w_a_addr;
        end
        MWRITE: begin
          dmem_wr_req = 1'b1;
          dmem_addr   = w_a_addr;
          dmem_wdata  = w_alu_out;
        end
        HALT:   halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= '0;
      r_a   <= 16'h0000;
      r_d   <= 16'h0000;
      r_ir  <= 16'h0000;
      r_inm <= 16'h0000;
    end else begin
      if ((w_state == FETCH) && imem_ack) r_ir <= imem_rdata;
      if ((w_state == MREAD) && dmem_ack) r_inm <= dmem_rdata;
      if (w_retire) begin
        if (!w_is_c) begin
          r_a <= {1'b0, r_ir[14:0]};
        end else begin
          if (r_ir[c_bit_d1]) r_a <= w_alu_out;
          if (r_ir[c_bit_d2]) r_d <= w_alu_out;
        end
        // Jump target uses A as it was before this instruction's write-back
        r_pc <= w_jump ? w_a_addr : (r_pc + c_pc_one);
      end
    end
  end

  assign imem_addr     = r_pc;
  assign debug_pc      = r_pc;
  assign debug_inst    = r_ir;
  assign debug_inM     = r_inm;
  assign debug_retired = w_retire;

endmodule
`default_nettype wire

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 15, giving the instruction and data address width (4..15).
REQ-002 The module SHALL have parameter HALT_DETECT, default 1, where 1 enables jump-to-self halt detection.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-low (0 = reset).
REQ-005 imem_req  out  1 / imem_addr  out  ADDR_W / imem_ack  in  1 / imem_rdata  in  16  form the instruction fetch handshake.
REQ-006 dmem_rd_req  out  1 / dmem_wr_req  out  1 / dmem_addr  out  ADDR_W / dmem_wdata  out  16 / dmem_ack  in  1 / dmem_rdata  in  16  form the data memory handshake.
REQ-007 step_en  in  1  selects single-step mode; step  in  1  is a one-cycle pulse that releases one instruction.
REQ-008 halted  out  1 / debug_pc  out  ADDR_W / debug_inst  out  16 / debug_inM  out  16 / debug_retired  out  1  are the debug outputs.

Function
REQ-009 The CPU SHALL execute the Hack ISA: bit15=0 is an A-instruction (A <= {0,inst[14:0]}); otherwise a C-instruction with fields a=inst[12], c=inst[11:6], d=inst[5:3], j=inst[2:0].
REQ-010 The FSM SHALL have states IDLE, FETCH, MREAD, EXEC, MWRITE and HALT; it leaves reset in FETCH, or in IDLE when step_en=1.
REQ-011 FETCH: imem_req=1 and imem_addr=PC; on imem_ack the FSM SHALL latch imem_rdata into IR and go to MREAD if IR is a C-instruction with a=1, else to EXEC.
REQ-012 MREAD: dmem_rd_req=1 and dmem_addr=A[ADDR_W-1:0]; on dmem_ack the FSM SHALL latch inM and go to EXEC.
REQ-013 EXEC: the ALU is evaluated; if d3=1 the FSM SHALL go to MWRITE with dmem_wdata=ALU output, else it retires.
REQ-014 MWRITE: dmem_wr_req=1 and dmem_addr=old A; on dmem_ack the instruction SHALL retire.
REQ-015 Retire SHALL occur in a single cycle: A/D written per d1/d2, PC updated, debug_retired=1 for exactly one cycle; the next state is FETCH, or IDLE when step_en=1.
REQ-016 Jumps: j1 taken if ALU<0, j2 if ALU==0, j3 if ALU>0; a taken jump loads PC=A[ADDR_W-1:0] using A before this instruction's write-back; otherwise PC=PC+1, wrapping modulo 2^ADDR_W.
REQ-017 Zero-wait latency SHALL be 2 cycles with no M access, 3 with an M read or an M write, and 4 with both.
REQ-018 Each request and its address/data SHALL be held stable until ack; an ack without a request SHALL be ignored; at most one request SHALL be active per cycle.
REQ-019 If HALT_DETECT=1 and a jump taken to target == current PC retires, the FSM SHALL enter HALT with halted=1 and no requests until reset.
REQ-020 IDLE SHALL issue no requests and move to FETCH on a cycle with step=1; step outside IDLE SHALL be ignored; clearing step_en in IDLE SHALL resume in FETCH.
REQ-021 debug_pc SHALL be PC, debug_inst SHALL be IR, and debug_inM SHALL be the last latched inM.

Reset
REQ-022 While reset=0, asynchronously: PC, A, D, IR, inM = 0; all requests, halted and debug_retired = 0; state = FETCH/IDLE per REQ-010.
REQ-023 Reset mid-handshake SHALL drop the request within the same cycle, discard the partial instruction, and leave A/D with no partial write.

Structure
REQ-024 A package hack_pkg SHALL hold the state enum, instruction field bit positions, jump-code constants and the 16-bit word typedef.
REQ-025 The combinational ALU (zx,nx,zy,ny,f,no → out,zr,ng) SHALL be a sub-module named hack_alu.

Verification
REQ-026 Program @2; D=A; @3; D=D+A; @0; M=D with zero-wait memories -> write to addr 0 with data 5; PC=6 after 6 retires; 13 cycles total.
REQ-027 imem_ack delayed 3 cycles -> imem_req/imem_addr stable for all 4 cycles; execution results same as REQ-026.
REQ-028 @7 at addr 6, 0;JMP at addr 7 -> halted=1 after the jump retires; no further requests; with HALT_DETECT=0 -> repeated fetch of addr 7.
REQ-029 step_en=1 with 3 step pulses spaced 10 cycles -> exactly 3 debug_retired pulses, PC=3.
REQ-030 reset=0 asserted while dmem_wr_req=1 -> dmem_wr_req=0 the same cycle; after release PC=0, D=0, fetch from addr 0.
REQ-031 ADDR_W=4, 16 A-instructions from addr 0 -> PC wraps 15→0 and fetch resumes at addr 0.
